// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: FSM states and the halt idiom.
package prog_loader_pkg;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2,
    ST_ERROR  = 2'd3
  } state_t;

  // jal x0,0 : the self-loop a program ends with so the loader can see a halt
  localparam logic [31:0] HALT_SELF_LOOP = 32'h0000_006F;

endpackage

// File: rtl/prog_loader_run_monitor.sv
// Watches the CPU PC while it runs and flags a self-loop halt or an exhausted
// cycle budget. The decisions are combinational; the loader registers them.
module prog_loader_run_monitor #(
  parameter int RUN_CYCLES = 300,
  parameter int CNT_W      = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        active,
  input  logic [31:0] cpu_pc,
  output logic        halt_hit,
  output logic        timeout_hit
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RUN_CYCLES - 1);

  logic [CNT_W-1:0] run_cnt;
  logic [31:0]      prev_pc;
  logic             pc_valid;

  // Count run cycles (saturating) and remember last cycle's PC while running
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt  <= '0;
      prev_pc  <= '0;
      pc_valid <= 1'b0;
    end else if (active) begin
      if (run_cnt != {CNT_W{1'b1}}) begin
        run_cnt <= run_cnt + CNT_W'(1);
      end
      prev_pc  <= cpu_pc;
      pc_valid <= 1'b1;
    end
  end

  assign halt_hit    = active && pc_valid && (cpu_pc == prev_pc);
  assign timeout_hit = active && (RUN_CYCLES != 0) && (run_cnt == LAST_CNT);

endmodule

// File: rtl/prog_loader.sv
// Streams a program into instruction memory, releases the CPU, then reports
// whether it halted on a self-loop or ran out of its cycle budget.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int RUN_CYCLES = 300,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              start,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_start,
  input  logic [31:0]       cpu_pc,
  output logic [ADDR_W:0]   word_count,
  output logic              done,
  output logic              timeout,
  output logic              load_err
);

  localparam logic [ADDR_W:0] LAST_SLOT = {1'b0, {ADDR_W{1'b1}}};

  state_t state, state_nxt;
  logic   handshake;
  logic   mon_active;
  logic   halt_hit;
  logic   timeout_hit;

  assign s_ready    = (state == ST_LOAD);
  assign handshake  = s_valid & s_ready;
  // The monitor only counts once the CPU has actually been released
  assign mon_active = (state == ST_RUN) & cpu_start;

  prog_loader_run_monitor #(
    .RUN_CYCLES (RUN_CYCLES),
    .CNT_W      (CNT_W)
  ) u_run_monitor (
    .clk         (clk),
    .rst_n       (start),
    .active      (mon_active),
    .cpu_pc      (cpu_pc),
    .halt_hit    (halt_hit),
    .timeout_hit (timeout_hit)
  );

  // State register
  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      state <= ST_LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode: load until s_last or memory full, then run until done
  always_comb begin
    state_nxt = state;
    case (state)
      ST_LOAD: begin
        if (handshake) begin
          if (s_last) begin
            state_nxt = ST_RUN;
          end else if (word_count == LAST_SLOT) begin
            state_nxt = ST_ERROR;
          end
        end
      end
      ST_RUN: begin
        if (halt_hit || timeout_hit) begin
          state_nxt = ST_HALTED;
        end
      end
      default: state_nxt = state;
    endcase
  end

  // Registered outputs; cpu_start lags RUN by a cycle so the last word lands first
  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      word_count <= '0;
      cpu_start  <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      imem_we <= handshake;
      if (handshake) begin
        imem_addr  <= word_count[ADDR_W-1:0];
        imem_wdata <= s_data;
        word_count <= word_count + (ADDR_W+1)'(1);
      end
      cpu_start <= (state == ST_RUN) || (state == ST_HALTED);
      load_err  <= (state_nxt == ST_ERROR);
      if ((state == ST_RUN) && (halt_hit || timeout_hit)) begin
        done    <= 1'b1;
        timeout <= ~halt_hit;
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: random programs, gaps and PC traces checked against
// a scenario-level model. A second instance (4-word memory, 2-cycle budget)
// covers overflow and the halt/timeout tie; both share the stimulus.
module tb_prog_loader
  import prog_loader_pkg::*;
;

  logic        clk;
  logic        start;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_last;
  logic [31:0] cpu_pc;

  logic        s_ready1, imem_we1, cpu_start1, done1, timeout1, load_err1;
  logic [7:0]  imem_addr1;
  logic [31:0] imem_wdata1;
  logic [8:0]  word_count1;

  logic        s_ready2, imem_we2, cpu_start2, done2, timeout2, load_err2;
  logic [1:0]  imem_addr2;
  logic [31:0] imem_wdata2;
  logic [2:0]  word_count2;

  bit          sel;
  logic        o_ready, o_we, o_start, o_done, o_to, o_err;
  logic [7:0]  o_addr;
  logic [31:0] o_wdata;
  logic [8:0]  o_wc;

  int          vectors;
  int          miscompares;
  logic [31:0] progQ[$];

  prog_loader dut (
    .clk(clk), .start(start), .s_valid(s_valid), .s_ready(s_ready1),
    .s_data(s_data), .s_last(s_last), .imem_we(imem_we1), .imem_addr(imem_addr1),
    .imem_wdata(imem_wdata1), .cpu_start(cpu_start1), .cpu_pc(cpu_pc),
    .word_count(word_count1), .done(done1), .timeout(timeout1), .load_err(load_err1)
  );

  prog_loader #(.ADDR_W(2), .RUN_CYCLES(2)) dut2 (
    .clk(clk), .start(start), .s_valid(s_valid), .s_ready(s_ready2),
    .s_data(s_data), .s_last(s_last), .imem_we(imem_we2), .imem_addr(imem_addr2),
    .imem_wdata(imem_wdata2), .cpu_start(cpu_start2), .cpu_pc(cpu_pc),
    .word_count(word_count2), .done(done2), .timeout(timeout2), .load_err(load_err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Select which instance the checks look at
  always_comb begin
    if (sel) begin
      o_ready = s_ready2;   o_we  = imem_we2;  o_start = cpu_start2;
      o_done  = done2;      o_to  = timeout2;  o_err   = load_err2;
      o_addr  = {6'b0, imem_addr2}; o_wdata = imem_wdata2; o_wc = {6'b0, word_count2};
    end else begin
      o_ready = s_ready1;   o_we  = imem_we1;  o_start = cpu_start1;
      o_done  = done1;      o_to  = timeout1;  o_err   = load_err1;
      o_addr  = imem_addr1; o_wdata = imem_wdata1; o_wc = word_count1;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h (dut%0d, t=%0t)", tag, got, exp, sel ? 2 : 1, $time);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetValues();
    checkOutput("rst_ready", 64'(o_ready), 64'(1));
    checkOutput("rst_we",    64'(o_we),    64'(0));
    checkOutput("rst_addr",  64'(o_addr),  64'(0));
    checkOutput("rst_wdata", 64'(o_wdata), 64'(0));
    checkOutput("rst_start", 64'(o_start), 64'(0));
    checkOutput("rst_wc",    64'(o_wc),    64'(0));
    checkOutput("rst_done",  64'(o_done),  64'(0));
    checkOutput("rst_to",    64'(o_to),    64'(0));
    checkOutput("rst_err",   64'(o_err),   64'(0));
  endtask

  task automatic applyReset();
    start   = 1'b0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
    cpu_pc  = '0;
    stepCycle();
    checkResetValues();
    start = 1'b1;
  endtask

  task automatic fillRandom(input int n);
    progQ.delete();
    for (int i = 0; i < n; i++) progQ.push_back($urandom);
  endtask

  // One full scenario: load progQ[0..nWords-1] with random gaps, then feed a
  // PC trace that advances by 4 for haltAfter cycles and then freezes.
  task automatic applyStimulus(input bit useSel, input int nWords, input bit giveLast,
                               input int gapLo, input int gapHi, input int haltAfter,
                               input logic [31:0] pcBase, input int abortAt);
    int cap, rc, gaps, th, expDone;
    bit expTo, lastHere;
    sel = useSel;
    cap = useSel ? 4 : 256;
    rc  = useSel ? 2 : 300;
    applyReset();

    for (int k = 0; k < nWords; k++) begin
      gaps = $urandom_range(gapHi, gapLo);
      for (int g = 0; g < gaps; g++) begin
        s_valid = 1'b0;
        s_data  = $urandom;
        s_last  = 1'($urandom);
        stepCycle();
        checkOutput("gap_we", 64'(o_we), 64'(0));
        checkOutput("gap_ready", 64'(o_ready), 64'(k < cap));
      end
      lastHere = giveLast && (k == nWords - 1);
      s_valid  = 1'b1;
      s_data   = progQ[k];
      s_last   = lastHere;
      checkOutput("ready_pre", 64'(o_ready), 64'(k < cap));
      stepCycle();
      s_valid = 1'b0;
      if (k < cap) begin
        checkOutput("wr_we",    64'(o_we),    64'(1));
        checkOutput("wr_addr",  64'(o_addr),  64'(k));
        checkOutput("wr_data",  64'(o_wdata), 64'(progQ[k]));
        checkOutput("wr_count", 64'(o_wc),    64'(k + 1));
        checkOutput("wr_err",   64'(o_err),   64'((k == cap - 1) && !lastHere));
      end else begin
        checkOutput("ovf_we",    64'(o_we),    64'(0));
        checkOutput("ovf_count", 64'(o_wc),    64'(cap));
        checkOutput("ovf_err",   64'(o_err),   64'(1));
        checkOutput("ovf_start", 64'(o_start), 64'(0));
        checkOutput("ovf_ready", 64'(o_ready), 64'(0));
      end
    end

    if (nWords > cap) begin
      stepCycle();
      checkOutput("err_hold", 64'(o_err),   64'(1));
      checkOutput("err_start", 64'(o_start), 64'(0));
      checkOutput("err_done", 64'(o_done),  64'(0));
      return;
    end

    checkOutput("start_lat", 64'(o_start), 64'(0));
    checkOutput("run_ready", 64'(o_ready), 64'(0));
    s_valid = 1'($urandom);
    stepCycle();
    checkOutput("start_rise", 64'(o_start), 64'(1));
    checkOutput("start_we",   64'(o_we),    64'(0));

    // First repeated PC appears at cycle haltAfter+1; budget expires at rc-1
    th = haltAfter + 1;
    if (rc != 0 && rc - 1 < th) begin
      expTo = 1'b1;  expDone = rc;
    end else begin
      expTo = 1'b0;  expDone = th + 1;
    end

    for (int t = 0; t <= expDone + 2; t++) begin
      if (t == abortAt) begin
        #3 start = 1'b0;
        #1;
        checkResetValues();
        return;
      end
      checkOutput("run_done",  64'(o_done),  64'(t >= expDone));
      checkOutput("run_to",    64'(o_to),    64'((t >= expDone) && expTo));
      checkOutput("run_start", 64'(o_start), 64'(1));
      checkOutput("run_we",    64'(o_we),    64'(0));
      cpu_pc  = pcBase + 32'(4 * ((t < haltAfter) ? t : haltAfter));
      s_valid = 1'($urandom);
      s_data  = $urandom;
      s_last  = 1'($urandom);
      stepCycle();
    end
    checkOutput("end_count", 64'(o_wc), 64'(nWords));
  endtask

  // Bound the whole run in case the design wedges
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got no completion expected finish before %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n, h;
    bit s, gl;
    vectors     = 0;
    miscompares = 0;
    sel         = 1'b0;
    start       = 1'b0;
    s_valid     = 1'b0;
    s_data      = '0;
    s_last      = 1'b0;
    cpu_pc      = '0;

    $display("[TB] directed: four-word program with self-loop halt");
    progQ = '{32'h00500093, 32'h00300113, 32'h002081B3, HALT_SELF_LOOP};
    applyStimulus(1'b0, 4, 1'b1, 0, 0, 0, 32'h0000000C, -1);

    $display("[TB] directed: valid gaps between words");
    fillRandom(3);
    applyStimulus(1'b0, 3, 1'b1, 1, 1, 2, $urandom & 32'hFFFF_FFFC, -1);

    $display("[TB] directed: run-cycle budget timeout");
    fillRandom(2);
    applyStimulus(1'b0, 2, 1'b1, 0, 2, 100000, $urandom & 32'hFFFF_FFFC, -1);

    $display("[TB] directed: overflow of a 4-word memory");
    fillRandom(5);
    applyStimulus(1'b1, 5, 1'b0, 0, 1, 0, 32'h0, -1);

    $display("[TB] directed: reset 50 cycles into a run, then reload");
    fillRandom(3);
    applyStimulus(1'b0, 3, 1'b1, 0, 1, 100000, $urandom & 32'hFFFF_FFFC, 50);
    fillRandom(1);
    applyStimulus(1'b0, 1, 1'b1, 0, 0, 1, $urandom & 32'hFFFF_FFFC, -1);

    $display("[TB] directed: halt and timeout in the same cycle");
    fillRandom(1);
    applyStimulus(1'b1, 1, 1'b1, 0, 0, 0, $urandom & 32'hFFFF_FFFC, -1);

    $display("[TB] random scenarios");
    for (int i = 0; i < 16; i++) begin
      s = 1'($urandom);
      n = s ? $urandom_range(6, 1) : $urandom_range(5, 1);
      gl = (n <= 4) ? 1'b1 : 1'($urandom);
      h = $urandom_range(25, 0);
      fillRandom(n);
      if (!s) gl = 1'b1;
      applyStimulus(s, n, gl, 0, 2, h, $urandom & 32'hFFFF_FFFC, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Synthesizable counterpart to the bench-side stimulus for SingleCycleCPU.
- Accepts a program as a valid/ready word stream and writes it into instruction memory.
- Releases the CPU by driving cpu_start, then monitors the CPU PC and reports halt (self-loop) or timeout.
- Sits between the host/UART front end, the instruction memory write port, and SingleCycleCPU's start input.

Parameters:
ADDR_W, 8, instruction-memory word-address width (capacity 2^ADDR_W words)
DATA_W, 32, instruction word width
RUN_CYCLES, 300, run-cycle budget before timeout; 0 disables the timeout
CNT_W, 16, run-cycle counter width; RUN_CYCLES < 2^CNT_W

Ports:
clk  in  1  system clock, rising edge
start  in  1  asynchronous active-low reset; low holds the block in reset
s_valid  in  1  program word valid
s_ready  out  1  loader ready to accept a word
s_data  in  DATA_W  program word
s_last  in  1  marks the final program word
imem_we  out  1  instruction-memory write enable
imem_addr  out  ADDR_W  instruction-memory word address
imem_wdata  out  DATA_W  instruction-memory write data
cpu_start  out  1  drives SingleCycleCPU start; 1 = run
cpu_pc  in  32  current CPU PC
word_count  out  ADDR_W+1  number of words loaded
done  out  1  run finished (halt or timeout)
timeout  out  1  run ended because the cycle budget was exhausted
load_err  out  1  program overflowed instruction memory

Behaviour:
- Reset (start=0, async): state LOAD; s_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, cpu_start=0, word_count=0, done=0, timeout=0, load_err=0; run counter, prev_pc and pc_valid cleared. Asserting reset mid-operation (any state) returns to this state immediately, with no partial write completed.
- States:
  - LOAD: s_ready=1.
    - A handshake is s_valid & s_ready at a clk edge.
    - On a handshake, registered outputs in the next cycle are imem_we=1, imem_addr=word_count, imem_wdata=s_data, and word_count increments. Write latency is 1 cycle.
    - imem_we is 0 in every cycle following a non-handshake.
    - Handshake with s_last=1 -> RUN.
    - Handshake with word_count == 2^ADDR_W-1 and s_last=0: the word is written, then -> ERROR.
    - s_valid=0 holds LOAD indefinitely.
  - RUN: s_ready=0, cpu_start=1. cpu_start rises in the cycle after the last write, so the last word is committed before the CPU fetches.
    - Each cycle: run counter increments (saturating), prev_pc<=cpu_pc, pc_valid<=1.
    - Halt: pc_valid=1 and cpu_pc == prev_pc (jal x0,0 self-loop) -> HALTED, done=1, timeout=0.
    - Timeout: RUN_CYCLES != 0 and counter == RUN_CYCLES-1 with no halt -> HALTED, done=1, timeout=1.
    - Halt and timeout in the same cycle: halt wins, timeout=0.
  - HALTED: terminal until reset. cpu_start stays 1 so CPU state remains observable. s_ready=0. done/timeout held.
  - ERROR: terminal until reset. load_err=1, s_ready=0, cpu_start=0, word_count=2^ADDR_W.
- Zero-length program is impossible: s_last is only meaningful with a handshake, and the first s_last word is word 0.
- In non-LOAD states, s_valid is ignored with no write. imem_addr and imem_wdata hold their last values.
- All outputs are registered. No combinational path from inputs to outputs except none: s_ready is a state decode.

Decomposition:
- Shared package/header:
  - state encoding localparams: ST_LOAD, ST_RUN, ST_HALTED, ST_ERROR
  - HALT_SELF_LOOP encoding constant 32'h0000006F, used by benches to build programs
- One natural sub-module: run_monitor (run counter, prev_pc/pc_valid, halt/timeout decision), instantiated by prog_loader.

Test Plan:
1. Load 4 words (0x00500093, 0x00300113, 0x002081B3, 0x0000006F; last on word 3), then hold cpu_pc=0x0C for 2 cycles -> imem writes at addr 0..3 with matching data; word_count=4; cpu_start rises the cycle after the addr-3 write; done=1, timeout=0 two cycles into the hold.
2. Backpressure/gaps: toggle s_valid 1,0,1,0 over 3 words -> exactly 3 writes at addr 0,1,2; imem_we low in the gap cycles.
3. Timeout with RUN_CYCLES=300 and cpu_pc incrementing by 4 each cycle -> done=1, timeout=1 exactly 300 cycles after cpu_start rises; cpu_start remains 1.
4. Overflow with ADDR_W=2: 5 words, no s_last -> 4 writes at addr 0..3, then load_err=1, word_count=4, 5th word not accepted (s_ready=0), cpu_start=0.
5. Reset mid-RUN: drop start after 50 run cycles -> all outputs return to reset values asynchronously; a new 1-word load then works from addr 0.
6. Halt and timeout coincide (RUN_CYCLES=2, cpu_pc constant) -> done=1, timeout=0.
